// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush scheduler:
// the stall bus layout, stall masks, FSM states and the default exception entry.
package pipe_ctrl_pkg;

  localparam int unsigned STALL_BUS = 6;
  localparam int unsigned DIV_CNT_W = 6;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  typedef logic [STALL_BUS-1:0] stall_t;

  // Masks are monotone: stopping a register also stops every register upstream of it.
  localparam stall_t STALL_NONE = {STALL_BUS{NOSTOP}};
  localparam stall_t STALL_IF   = 6'b000011;
  localparam stall_t STALL_ID   = 6'b000111;
  localparam stall_t STALL_EXE  = 6'b001111;
  localparam stall_t STALL_MEM  = 6'b011111;
  localparam stall_t STALL_ALL  = {STALL_BUS{STOP}};

  localparam logic [31:0] EXC_ENTRY_DEFAULT = 32'hBFC00380;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_FLUSH_WAIT = 2'd1,
    ST_FLUSH      = 2'd2
  } state_e;

  function automatic logic [31:0] redirect_target(input logic        is_eret,
                                                  input logic [31:0] epc,
                                                  input logic [31:0] entry);
    return is_eret ? epc : entry;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the stall/flush scheduler.
interface pipe_ctrl_if;

  logic        stallreq_if;
  logic        stallreq_id;
  logic        div_start;
  logic        stallreq_mem;
  logic        ibus_busy;
  logic        exc_req;
  logic        exc_is_eret;
  logic [31:0] cp0_epc;

  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        div_busy;

  modport master (
    output stallreq_if, stallreq_id, div_start, stallreq_mem,
           ibus_busy, exc_req, exc_is_eret, cp0_epc,
    input  stall, flush, flush_pc, div_busy
  );

  modport slave (
    input  stallreq_if, stallreq_id, div_start, stallreq_mem,
           ibus_busy, exc_req, exc_is_eret, cp0_epc,
    output stall, flush, flush_pc, div_busy
  );

endinterface

// File: rtl/pipe_ctrl_div_stall_cnt.sv
// Multi-cycle divide stall timer: holds busy for CYCLES-1 cycles after a start
// pulse seen while idle; a clear empties it regardless of its state.
module div_stall_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CYCLES = 34
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic clear_i,
  output logic busy_o
);

  localparam logic [DIV_CNT_W-1:0] LOAD_VAL = DIV_CNT_W'(CYCLES - 1);

  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The counter free-runs once loaded; pipeline stalls never hold it.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else if (start_i) begin
      cnt_d = LOAD_VAL;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush scheduler: merges stage stall requests, times divides,
// and sequences exception/eret flushes so they never overlap an open fetch.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 34,
  parameter logic [31:0] EXC_ENTRY  = EXC_ENTRY_DEFAULT
) (
  input  logic       cpu_clk_50M,
  input  logic       cpu_rst,
  pipe_ctrl_if.slave bus
);

  state_e      state_q, state_d;
  logic [31:0] target_q, target_d;
  logic [31:0] flush_pc_q, flush_pc_d;

  stall_t      stall;
  logic        flush;
  logic        div_busy;
  logic        div_clear;

  div_stall_cnt #(
    .CYCLES (DIV_CYCLES)
  ) u_div_cnt (
    .clk_i   (cpu_clk_50M),
    .rst_i   (cpu_rst),
    .start_i (bus.div_start),
    .clear_i (div_clear),
    .busy_o  (div_busy)
  );

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_q    <= ST_RUN;
      target_q   <= '0;
      flush_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  // flush_pc is only updated on entry to FLUSH so it stays stable while waiting.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    flush_pc_d = flush_pc_q;
    case (state_q)
      ST_RUN: begin
        if (bus.exc_req) begin
          target_d = redirect_target(bus.exc_is_eret, bus.cp0_epc, EXC_ENTRY);
          if (bus.ibus_busy) begin
            state_d = ST_FLUSH_WAIT;
          end else begin
            state_d    = ST_FLUSH;
            flush_pc_d = target_d;
          end
        end
      end
      ST_FLUSH_WAIT: begin
        if (!bus.ibus_busy) begin
          state_d    = ST_FLUSH;
          flush_pc_d = target_q;
        end
      end
      ST_FLUSH: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    stall     = STALL_NONE;
    flush     = 1'b0;
    div_clear = 1'b0;
    case (state_q)
      ST_FLUSH_WAIT: begin
        stall = STALL_ALL;
      end
      ST_FLUSH: begin
        flush     = 1'b1;
        div_clear = 1'b1;
      end
      default: begin
        if (bus.stallreq_mem) begin
          stall = STALL_MEM;
        end else if (div_busy) begin
          stall = STALL_EXE;
        end else if (bus.stallreq_id) begin
          stall = STALL_ID;
        end else if (bus.stallreq_if) begin
          stall = STALL_IF;
        end
      end
    endcase
  end

  assign bus.stall    = stall;
  assign bus.flush    = flush;
  assign bus.flush_pc = flush_pc_q;
  assign bus.div_busy = div_busy;

endmodule
